// File: rtl/ula_multiciclo.sv
// -----------------------------------------------------------------------------
// ula_multiciclo
// Multi-cycle ALU for the MIPS execute stage. It is the registered successor to
// the single-cycle ALU.
//   - Logic, add/sub, slt/sltu and jal complete one cycle after accept.
//   - mult (unsigned shift-add) and div (unsigned restoring) iterate WIDTH
//     times. They complete WIDTH+1 cycles after accept.
//   - HI receives the upper product half (mult) or the remainder (div).
//   - erro flags divide-by-zero and undefined opcodes.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   inicio     in   1       start strobe, accepted only while ocupado=0
//   ALU_Ctrl   in   CTRL_W  opcode, sampled at accept
//   dados1     in   WIDTH   operand A, sampled at accept
//   dados2     in   WIDTH   operand B, sampled at accept
//   resultado  out  WIDTH   registered result (LO)
//   hi         out  WIDTH   upper product half / remainder
//   zero       out  1       resultado == 0
//   erro       out  1       divide-by-zero or undefined opcode
//   ocupado    out  1       busy, from accept through the pronto cycle
//   pronto     out  1       one-cycle pulse, outputs valid
// -----------------------------------------------------------------------------
module ula_multiciclo #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inicio,
   input  logic [CTRL_W-1:0] ALU_Ctrl,
   input  logic [WIDTH-1:0]  dados1,
   input  logic [WIDTH-1:0]  dados2,
   output logic [WIDTH-1:0]  resultado,
   output logic [WIDTH-1:0]  hi,
   output logic              zero,
   output logic              erro,
   output logic              ocupado,
   output logic              pronto
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(6'b000000);
   localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(6'b000001);
   localparam logic [CTRL_W-1:0] OP_MULT = CTRL_W'(6'b000010);
   localparam logic [CTRL_W-1:0] OP_DIV  = CTRL_W'(6'b000011);
   localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(6'b000100);
   localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(6'b000101);
   localparam logic [CTRL_W-1:0] OP_NOT  = CTRL_W'(6'b000110);
   localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(6'b000111);
   localparam logic [CTRL_W-1:0] OP_XOR  = CTRL_W'(6'b001000);
   localparam logic [CTRL_W-1:0] OP_NOR  = CTRL_W'(6'b001001);
   localparam logic [CTRL_W-1:0] OP_XNOR = CTRL_W'(6'b001010);
   localparam logic [CTRL_W-1:0] OP_SLTU = CTRL_W'(6'b001011);
   localparam logic [CTRL_W-1:0] OP_JAL  = CTRL_W'(6'b100000);

   // EXECUTA is the single evaluation cycle for one-cycle ops. In that cycle
   // the operands latched at accept produce the result registered into FIM.
   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      EXECUTA = 2'd1,
      ITERA   = 2'd2,
      FIM     = 2'd3
   } estado_t;

   estado_t              state_q, state_d;

   // Operands latched at accept
   logic [CTRL_W-1:0]    op_q;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;

   // Iteration state. For mult, acc = {partial product, multiplier}.
   // For div, acc = {remainder, dividend/quotient}.
   logic [2*WIDTH-1:0]   acc_q;
   logic [CNT_W-1:0]     cnt_q;

   // Registered outputs
   logic [WIDTH-1:0]     resultado_q, res_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic                 zero_q, zero_d;
   logic                 erro_q, erro_d;
   logic                 ocupado_q, ocupado_d;
   logic                 pronto_q, pronto_d;

   logic                 aceita_s;
   logic                 inicia_itera_s;
   logic                 fim_itera_s;

   logic [WIDTH-1:0]     simp_res_s;
   logic [WIDTH-1:0]     simp_hi_s;
   logic                 simp_err_s;

   logic [WIDTH:0]       soma_s;
   logic [2*WIDTH-1:0]   mult_prox_s;
   logic [WIDTH:0]       rem_sh_s;
   logic                 ge_s;
   logic [WIDTH-1:0]     rem_novo_s;
   logic [2*WIDTH-1:0]   div_prox_s;
   logic [2*WIDTH-1:0]   acc_prox_s;

   assign aceita_s       = (state_q == OCIOSO) && inicio;
   // A divide by zero resolves in one cycle, so it never enters ITERA.
   assign inicia_itera_s = (ALU_Ctrl == OP_MULT) ||
                           ((ALU_Ctrl == OP_DIV) && (dados2 != {WIDTH{1'b0}}));
   assign fim_itera_s    = (cnt_q == CNT_W'(WIDTH));

   // Shift-add multiply step and restoring divide step
   always_comb begin
      soma_s      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    ({1'b0, b_q} & {(WIDTH+1){acc_q[0]}});
      mult_prox_s = {soma_s, acc_q[WIDTH-1:1]};

      // The remainder is always below the divisor, so after the shift it needs
      // one extra bit. After a successful subtract it fits back in WIDTH bits.
      rem_sh_s    = acc_q[2*WIDTH-1:WIDTH-1];
      ge_s        = (rem_sh_s >= {1'b0, b_q});
      if (ge_s) begin
         rem_novo_s = rem_sh_s[WIDTH-1:0] - b_q;
      end else begin
         rem_novo_s = rem_sh_s[WIDTH-1:0];
      end
      div_prox_s  = {rem_novo_s, acc_q[WIDTH-2:0], ge_s};

      if (op_q == OP_DIV) begin
         acc_prox_s = div_prox_s;
      end else begin
         acc_prox_s = mult_prox_s;
      end
   end

   // Single-cycle datapath evaluated from the latched operands
   always_comb begin
      simp_res_s = {WIDTH{1'b0}};
      simp_hi_s  = hi_q;
      simp_err_s = 1'b0;
      case (op_q)
         OP_ADD:  simp_res_s = a_q + b_q;
         OP_SUB:  simp_res_s = a_q - b_q;
         OP_OR:   simp_res_s = a_q | b_q;
         OP_AND:  simp_res_s = a_q & b_q;
         OP_NOT:  simp_res_s = ~a_q;
         OP_XOR:  simp_res_s = a_q ^ b_q;
         OP_NOR:  simp_res_s = ~(a_q | b_q);
         OP_XNOR: simp_res_s = ~(a_q ^ b_q);
         OP_SLT:  simp_res_s = WIDTH'($signed(a_q) < $signed(b_q));
         OP_SLTU: simp_res_s = WIDTH'(a_q < b_q);
         OP_JAL:  simp_res_s = {WIDTH{1'b0}};
         // This point is reached only with a zero divisor
         OP_DIV: begin
            simp_res_s = {WIDTH{1'b1}};
            simp_hi_s  = a_q;
            simp_err_s = 1'b1;
         end
         default: begin
            simp_res_s = {WIDTH{1'b0}};
            simp_err_s = 1'b1;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OCIOSO;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         OCIOSO: begin
            if (inicio) begin
               state_d = inicia_itera_s ? ITERA : EXECUTA;
            end else begin
               state_d = OCIOSO;
            end
         end
         EXECUTA: state_d = FIM;
         ITERA: begin
            if (fim_itera_s) begin
               state_d = FIM;
            end else begin
               state_d = ITERA;
            end
         end
         FIM:     state_d = OCIOSO;
         default: state_d = OCIOSO;
      endcase
   end

   // FSM output logic: visible results change only on entry to FIM
   always_comb begin
      res_d  = resultado_q;
      hi_d   = hi_q;
      erro_d = erro_q;
      case (state_q)
         EXECUTA: begin
            res_d  = simp_res_s;
            hi_d   = simp_hi_s;
            erro_d = simp_err_s;
         end
         ITERA: begin
            if (fim_itera_s) begin
               res_d  = acc_q[WIDTH-1:0];
               hi_d   = acc_q[2*WIDTH-1:WIDTH];
               erro_d = 1'b0;
            end else begin
               res_d  = resultado_q;
               hi_d   = hi_q;
               erro_d = erro_q;
            end
         end
         default: begin
            res_d  = resultado_q;
            hi_d   = hi_q;
            erro_d = erro_q;
         end
      endcase
      zero_d    = (res_d == {WIDTH{1'b0}});
      ocupado_d = (state_d != OCIOSO);
      pronto_d  = (state_d == FIM);
   end

   // Operand latch and iteration accumulator/counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q  <= {CTRL_W{1'b0}};
         a_q   <= {WIDTH{1'b0}};
         b_q   <= {WIDTH{1'b0}};
         acc_q <= {(2*WIDTH){1'b0}};
         cnt_q <= {CNT_W{1'b0}};
      end else if (aceita_s) begin
         op_q  <= ALU_Ctrl;
         a_q   <= dados1;
         b_q   <= dados2;
         // dados1 is the multiplier for mult and the dividend for div
         acc_q <= {{WIDTH{1'b0}}, dados1};
         cnt_q <= {CNT_W{1'b0}};
      end else if ((state_q == ITERA) && !fim_itera_s) begin
         acc_q <= acc_prox_s;
         cnt_q <= cnt_q + CNT_W'(1);
      end else begin
         acc_q <= acc_q;
         cnt_q <= cnt_q;
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resultado_q <= {WIDTH{1'b0}};
         hi_q        <= {WIDTH{1'b0}};
         zero_q      <= 1'b1;
         erro_q      <= 1'b0;
         ocupado_q   <= 1'b0;
         pronto_q    <= 1'b0;
      end else begin
         resultado_q <= res_d;
         hi_q        <= hi_d;
         zero_q      <= zero_d;
         erro_q      <= erro_d;
         ocupado_q   <= ocupado_d;
         pronto_q    <= pronto_d;
      end
   end

   assign resultado = resultado_q;
   assign hi        = hi_q;
   assign zero      = zero_q;
   assign erro      = erro_q;
   assign ocupado   = ocupado_q;
   assign pronto    = pronto_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// -----------------------------------------------------------------------------
// tb_ula_multiciclo
// Self-checking bench for ula_multiciclo (WIDTH=32).
//   - A vector table drives operations one at a time.
//   - Expected results and completion cycles go onto a scoreboard queue at
//     accept. They are compared whenever pronto pulses.
//   - Hand-written sequences cover:
//       * inicio held high through a mult while the operands keep changing;
//       * the back-to-back accept that follows it;
//       * an asynchronous reset in the middle of ITERA.
// -----------------------------------------------------------------------------
module tb_ula_multiciclo;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_MULT = 6'b000010;
   localparam logic [5:0] OP_DIV  = 6'b000011;
   localparam logic [5:0] OP_OR   = 6'b000100;
   localparam logic [5:0] OP_AND  = 6'b000101;
   localparam logic [5:0] OP_NOT  = 6'b000110;
   localparam logic [5:0] OP_SLT  = 6'b000111;
   localparam logic [5:0] OP_XOR  = 6'b001000;
   localparam logic [5:0] OP_NOR  = 6'b001001;
   localparam logic [5:0] OP_XNOR = 6'b001010;
   localparam logic [5:0] OP_SLTU = 6'b001011;
   localparam logic [5:0] OP_JAL  = 6'b100000;
   localparam logic [5:0] OP_ILEG = 6'b111111;

   logic        clk;
   logic        rst_n;
   logic        inicio;
   logic [5:0]  ALU_Ctrl;
   logic [31:0] dados1;
   logic [31:0] dados2;
   logic [31:0] resultado;
   logic [31:0] hi;
   logic        zero;
   logic        erro;
   logic        ocupado;
   logic        pronto;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        hi_wr;
      logic [31:0] hi_v;
      logic        err;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [31:0] hi_v;
      logic        err;
      int          cyc;
      int          tag;
   } exp_t;

   exp_t        sb_q[$];
   vec_t        tab[19];
   int          checks;
   int          failures;
   int          cyc;
   logic [31:0] hi_model;
   logic [63:0] prod;
   logic [31:0] ra;
   logic [31:0] rb;
   int          n_pronto;
   int          acc_cyc;

   ula_multiciclo #(.WIDTH(32), .CTRL_W(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inicio    (inicio),
      .ALU_Ctrl  (ALU_Ctrl),
      .dados1    (dados1),
      .dados2    (dados2),
      .resultado (resultado),
      .hi        (hi),
      .zero      (zero),
      .erro      (erro),
      .ocupado   (ocupado),
      .pronto    (pronto)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter, advanced at each active edge
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks = checks + 1;
      if (act !== req) begin
         failures = failures + 1;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
      end
   endtask

   // Scoreboard consumer: compares every pronto pulse against the oldest entry
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && pronto) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_pronto", {63'd0, pronto}, 64'd0);
         end else begin
            e = sb_q.pop_front();
            chk($sformatf("op%0d_resultado", e.tag), {32'd0, resultado}, {32'd0, e.res});
            chk($sformatf("op%0d_hi", e.tag), {32'd0, hi}, {32'd0, e.hi_v});
            chk($sformatf("op%0d_zero", e.tag), {63'd0, zero}, {63'd0, (e.res == 32'd0)});
            chk($sformatf("op%0d_erro", e.tag), {63'd0, erro}, {63'd0, e.err});
            chk($sformatf("op%0d_cycle", e.tag), 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic push_exp(input logic [31:0] res, input logic hw, input logic [31:0] hv,
                           input logic er, input int lat, input int tag);
      exp_t e;
      if (hw) hi_model = hv;
      e.res  = res;
      e.hi_v = hi_model;
      e.err  = er;
      // Drive happens at a negedge; the next posedge is cycle 0
      e.cyc  = cyc + 1 + lat;
      e.tag  = tag;
      sb_q.push_back(e);
   endtask

   task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic hw, input logic [31:0] hv,
                         input logic er, input int lat, input int tag);
      int t;
      t = 0;
      @(negedge clk);
      while (ocupado && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (ocupado) chk("timeout_idle", {63'd0, ocupado}, 64'd0);
      ALU_Ctrl = op;
      dados1   = a;
      dados2   = b;
      inicio   = 1'b1;
      push_exp(res, hw, hv, er, lat, tag);
      @(negedge clk);
      inicio   = 1'b0;
      // Operands scrambled after accept must not matter
      dados1   = $urandom;
      dados2   = $urandom;
      ALU_Ctrl = OP_SUB;
      t = 0;
      while (sb_q.size() != 0 && t < 100) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (sb_q.size() != 0) begin
         chk("timeout_pronto", 64'(sb_q.size()), 64'd0);
         sb_q.delete();
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      hi_model = 32'd0;
      rst_n    = 1'b0;
      inicio   = 1'b0;
      ALU_Ctrl = 6'd0;
      dados1   = 32'd0;
      dados2   = 32'd0;

      //        op       a             b             res           hw    hi            err   lat
      tab[0]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 32'h0,        1'b0, 1};
      tab[1]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 32'h0,        1'b0, 1};
      tab[2]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 32'h0,        1'b0, 1};
      tab[3]  = '{OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'hFFFFFFFE, 1'b0, 33};
      tab[4]  = '{OP_DIV,  32'd100,      32'd7,        32'd14,       1'b1, 32'd2,        1'b0, 33};
      tab[5]  = '{OP_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 32'd5,        1'b1, 1};
      tab[6]  = '{OP_ILEG, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 32'h0,        1'b1, 1};
      tab[7]  = '{OP_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 32'h0,        1'b0, 1};
      tab[8]  = '{OP_SUB,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 32'h0,        1'b0, 1};
      tab[9]  = '{OP_OR,   32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 32'h0,        1'b0, 1};
      tab[10] = '{OP_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 32'h0,        1'b0, 1};
      tab[11] = '{OP_NOT,  32'h0000FFFF, 32'h12345678, 32'hFFFF0000, 1'b0, 32'h0,        1'b0, 1};
      tab[12] = '{OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, 1};
      tab[13] = '{OP_XNOR, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, 1};
      tab[14] = '{OP_JAL,  32'h00001234, 32'h00005678, 32'h00000000, 1'b0, 32'h0,        1'b0, 1};
      tab[15] = '{OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h0,        1'b0, 1};
      tab[16] = '{OP_MULT, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 33};
      tab[17] = '{OP_DIV,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b1, 32'd0,        1'b0, 33};
      tab[18] = '{OP_DIV,  32'd3,        32'd10,       32'd0,        1'b1, 32'd3,        1'b0, 33};

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_resultado", {32'd0, resultado}, 64'd0);
      chk("rst_hi", {32'd0, hi}, 64'd0);
      chk("rst_zero", {63'd0, zero}, 64'd1);
      chk("rst_erro", {63'd0, erro}, 64'd0);
      chk("rst_ocupado", {63'd0, ocupado}, 64'd0);
      chk("rst_pronto", {63'd0, pronto}, 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         run_op(tab[i].op, tab[i].a, tab[i].b, tab[i].res, tab[i].hi_wr,
                tab[i].hi_v, tab[i].err, tab[i].lat, i);
      end

      // Random mult/div against a 64-bit reference
      for (int i = 0; i < 4; i++) begin
         ra   = $urandom;
         rb   = $urandom;
         prod = 64'(ra) * 64'(rb);
         run_op(OP_MULT, ra, rb, prod[31:0], 1'b1, prod[63:32], 1'b0, 33, 100 + i);
         rb   = 32'($urandom_range(65535, 1));
         run_op(OP_DIV, ra, rb, ra / rb, 1'b1, ra % rb, 1'b0, 33, 200 + i);
      end

      // inicio held high through a mult while the inputs keep changing
      @(negedge clk);
      ALU_Ctrl = OP_MULT;
      dados1   = 32'd3;
      dados2   = 32'd4;
      inicio   = 1'b1;
      push_exp(32'd12, 1'b1, 32'd0, 1'b0, 33, 300);
      acc_cyc = cyc + 1;
      for (int i = 0; i <= 33; i++) begin
         @(negedge clk);
         chk($sformatf("held_ocupado_c%0d", cyc - acc_cyc), {63'd0, ocupado}, 64'd1);
         ALU_Ctrl = (i % 2 == 0) ? OP_ADD : OP_DIV;
         dados1   = $urandom;
         dados2   = $urandom;
      end
      @(negedge clk);
      chk("held_idle_ocupado", {63'd0, ocupado}, 64'd0);
      chk("held_hold_res_idle", {32'd0, resultado}, 64'd12);
      ALU_Ctrl = OP_ADD;
      dados1   = 32'd7;
      dados2   = 32'd8;
      push_exp(32'd15, 1'b0, 32'd0, 1'b0, 1, 301);
      @(negedge clk);
      inicio = 1'b0;
      chk("b2b_accepted", {63'd0, ocupado}, 64'd1);
      chk("held_hold_res_exec", {32'd0, resultado}, 64'd12);
      for (int t = 0; t < 10 && sb_q.size() != 0; t++) begin
         @(negedge clk);
         #1;
      end
      chk("b2b_drained", 64'(sb_q.size()), 64'd0);
      sb_q.delete();

      // Leave nonzero outputs, then abort a mult with an asynchronous reset
      run_op(OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 32'd5, 1'b1, 1, 400);
      @(negedge clk);
      ALU_Ctrl = OP_MULT;
      dados1   = 32'hFFFFFFFF;
      dados2   = 32'hFFFFFFFF;
      inicio   = 1'b1;
      @(negedge clk);
      inicio = 1'b0;
      repeat (10) @(negedge clk);
      chk("pre_rst_ocupado", {63'd0, ocupado}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_resultado", {32'd0, resultado}, 64'd0);
      chk("arst_hi", {32'd0, hi}, 64'd0);
      chk("arst_zero", {63'd0, zero}, 64'd1);
      chk("arst_erro", {63'd0, erro}, 64'd0);
      chk("arst_ocupado", {63'd0, ocupado}, 64'd0);
      chk("arst_pronto", {63'd0, pronto}, 64'd0);
      hi_model = 32'd0;
      @(negedge clk);
      rst_n    = 1'b1;
      n_pronto = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (pronto) n_pronto++;
      end
      chk("arst_no_pronto", 64'(n_pronto), 64'd0);
      chk("arst_idle", {63'd0, ocupado}, 64'd0);

      // Recovery after reset
      run_op(OP_ADD, 32'd20, 32'd22, 32'd42, 1'b0, 32'd0, 1'b0, 1, 500);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
- Parametrised, registered successor to the single-cycle ALU.
- Logic, add/sub and compare ops finish in 1 cycle; multiply and divide run iteratively (shift-add / restoring) over WIDTH cycles, with a start/busy/done handshake.
- Sits in the MIPS execute stage; control stalls the pipeline while ocupado=1.
- Adds a HI register (upper product / remainder), signed and unsigned slt, and a divide-by-zero/illegal-op flag.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CTRL_W, 6, width of ALU_Ctrl.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- inicio  input  1  start strobe; accepted only when ocupado=0.
- ALU_Ctrl  input  CTRL_W  operation code, sampled at accept.
- dados1  input  WIDTH  operand A, sampled at accept.
- dados2  input  WIDTH  operand B, sampled at accept.
- resultado  output  WIDTH  registered result (LO).
- hi  output  WIDTH  upper product half (mult) / remainder (div); unchanged by other ops.
- zero  output  1  registered, =1 iff resultado==0; updated with resultado.
- erro  output  1  =1 for divide-by-zero or undefined opcode; valid with pronto.
- ocupado  output  1  high from accept until the cycle pronto is asserted (inclusive).
- pronto  output  1  one-cycle pulse: resultado/hi/zero/erro are valid.

Behaviour:
- Reset (async, rst_n=0): state OCIOSO; resultado=0, hi=0, zero=1, erro=0, ocupado=0, pronto=0, internal counter/registers cleared. Reset mid-operation aborts immediately; no pronto.
- Accept: rising edge with inicio=1 and ocupado=0 latches ALU_Ctrl, dados1, dados2. inicio while ocupado=1 is ignored (not queued).
- States: OCIOSO -> (accept, single-cycle op) -> FIM; OCIOSO -> (accept, mult/div with divisor≠0) -> ITERA; ITERA -> (counter reaches WIDTH) -> FIM; FIM -> OCIOSO. pronto=1 exactly in FIM.
- Latency (accept edge = cycle 0): single-cycle ops and div-by-zero: pronto in cycle 1. Mult/div: pronto in cycle WIDTH+1.
- Back-to-back: inicio accepted in the cycle after FIM (ocupado=0 in OCIOSO).
- Opcodes (all arithmetic modulo 2^WIDTH unless stated):
  - 000000 add; 000001 sub.
  - 000010 mult: unsigned, 2*WIDTH-bit product; resultado=low half, hi=high half.
  - 000011 div: unsigned; resultado=quotient, hi=remainder.
  - 000100 or; 000101 and; 000110 not (~dados1); 001000 xor (dados1^dados2); 001001 nor; 001010 xnor.
  - 000111 slt: signed two's-complement, result 1/0.
  - 001011 sltu: unsigned, result 1/0.
  - 100000 jal: resultado=0.
- Divide by zero: resultado=all ones, hi=dados1, erro=1, 1-cycle latency.
- Undefined opcode: resultado=0, erro=1, hi unchanged, 1-cycle latency.
- resultado/hi/zero/erro hold their values from pronto until the next FIM; they never show intermediate iteration values (use internal accumulators).
- Operand inputs may change freely after accept without affecting the result.

Test Plan:
- Reset: rst_n=0 asynchronously mid-ITERA -> outputs return to reset values within the same cycle, ocupado=0, no pronto after release.
- add 0xFFFFFFFF+1 -> pronto at cycle 1, resultado=0, zero=1, erro=0; slt 0xFFFFFFFF vs 1 -> 1; sltu same operands -> 0.
- mult 0xFFFFFFFF*0xFFFFFFFF -> pronto at cycle 33, resultado=0x00000001, hi=0xFFFFFFFE; ocupado=1 in cycles 0..33.
- div 100/7 -> resultado=14, hi=2, pronto at cycle 33; div 5/0 -> cycle 1, resultado=0xFFFFFFFF, hi=5, erro=1.
- inicio held high during a mult with changing operands/op -> only the first op executes; next op accepted in the cycle after pronto, and resultado of the mult holds until that op's pronto.
- Opcode 111111 -> resultado=0, erro=1, hi unchanged; xor 0xF0F0F0F0^0x0FF00FF0 -> 0xFF00FF00.
